ws2812_receiver: RTL

Serial decoder for the WS2812 single-wire LED protocol: samples the data line, classifies each high pulse as a 0 or 1 by its width, and assembles MSB-first 24-bit pixel words. It detects the low-time latch that ends a frame and flags malformed traffic. It is the receive end of `ws2812_driver`: it serves as a loopback checker in simulation and on hardware, and as the input stage for a daisy-chained hologram board.

---
 rtl/ws2812_receiver.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ws2812_receiver.sv
// ws2812_receiver
//   Decodes a WS2812 single-wire stream into 24-bit pixel words. Each high
//   pulse is classified as 0/1 by its width. Words are assembled MSB-first.
//   A long low period latches (ends) the frame. Malformed traffic is flagged.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   din           raw WS2812 line (asynchronous to clk)
//   pixel_data    last complete word, first received bit in [23]
//   pixel_index   position of pixel_data within the frame
//   pixel_valid   1-cycle strobe qualifying pixel_data / pixel_index
//   frame_done    1-cycle strobe on a valid latch
//   frame_pixels  complete pixels in the frame just ended
//   bit_error     1-cycle strobe: glitch, over-long high, partial pixel at latch
//   overflow      1-cycle strobe on the first word beyond LED_COUNT in a frame
//   busy          decoding a frame (HIGH or LOW state)
module ws2812_receiver #(
    parameter int LED_COUNT     = 8,
    parameter int THRESH_CYCLES = 30,
    parameter int MIN_HIGH      = 8,
    parameter int MAX_HIGH      = 60,
    parameter int LATCH_CYCLES  = 2500
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             din,
    output logic [23:0]                      pixel_data,
    output logic [$clog2(LED_COUNT)-1:0]     pixel_index,
    output logic                             pixel_valid,
    output logic                             frame_done,
    output logic [$clog2(LED_COUNT+1)-1:0]   frame_pixels,
    output logic                             bit_error,
    output logic                             overflow,
    output logic                             busy
);
    localparam int PW = $clog2(LED_COUNT+1);
    localparam int IW = $clog2(LED_COUNT);
    localparam int HW = $clog2(MAX_HIGH+1);
    localparam int LW = $clog2(LATCH_CYCLES+1);

    localparam logic [HW-1:0] THR_C   = HW'(THRESH_CYCLES);
    localparam logic [HW-1:0] MINH_C  = HW'(MIN_HIGH);
    localparam logic [HW-1:0] MAXH_M1 = HW'(MAX_HIGH-1);
    localparam logic [LW-1:0] LAT_M1  = LW'(LATCH_CYCLES-1);
    localparam logic [PW-1:0] LED_C   = PW'(LED_COUNT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT_LATCH} state_t;

    state_t        state, state_n;
    logic          sync1, din_s, din_d;
    logic [HW-1:0] high_cnt, high_n;
    logic [LW-1:0] low_cnt, low_n;
    logic [4:0]    bit_cnt, bit_n;
    logic [PW-1:0] pix_cnt, pix_n;
    logic [23:0]   shreg, shreg_n;
    logic          ovf_seen, ovf_seen_n;
    logic [23:0]   data_n;
    logic [IW-1:0] idx_n;
    logic [PW-1:0] fpix_n;
    logic          pv_n, fd_n, be_n, ov_n;

    logic          rise, fall, bit_val;
    logic [23:0]   word;

    assign rise    = din_s & ~din_d;
    assign fall    = ~din_s & din_d;
    assign bit_val = (high_cnt >= THR_C);
    assign word    = {shreg[22:0], bit_val};
    assign busy    = (state == HIGH) || (state == LOW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= 1'b0;
            din_s        <= 1'b0;
            din_d        <= 1'b0;
            state        <= IDLE;
            high_cnt     <= '0;
            low_cnt      <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            shreg        <= '0;
            ovf_seen     <= 1'b0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            frame_pixels <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            bit_error    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            sync1        <= din;
            din_s        <= sync1;
            din_d        <= din_s;
            state        <= state_n;
            high_cnt     <= high_n;
            low_cnt      <= low_n;
            bit_cnt      <= bit_n;
            pix_cnt      <= pix_n;
            shreg        <= shreg_n;
            ovf_seen     <= ovf_seen_n;
            pixel_data   <= data_n;
            pixel_index  <= idx_n;
            frame_pixels <= fpix_n;
            pixel_valid  <= pv_n;
            frame_done   <= fd_n;
            bit_error    <= be_n;
            overflow     <= ov_n;
        end
    end

    always_comb begin
        state_n    = state;
        high_n     = high_cnt;
        low_n      = low_cnt;
        bit_n      = bit_cnt;
        pix_n      = pix_cnt;
        shreg_n    = shreg;
        ovf_seen_n = ovf_seen;
        data_n     = pixel_data;
        idx_n      = pixel_index;
        fpix_n     = frame_pixels;
        pv_n       = 1'b0;
        fd_n       = 1'b0;
        be_n       = 1'b0;
        ov_n       = 1'b0;

        case (state)
            IDLE: begin
                high_n     = '0;
                low_n      = '0;
                bit_n      = '0;
                pix_n      = '0;
                ovf_seen_n = 1'b0;
                if (rise) begin
                    state_n = HIGH;
                    high_n  = HW'(1);
                end
            end

            HIGH: begin
                if (fall) begin
                    if (high_cnt < MINH_C) begin
                        be_n    = 1'b1;
                        state_n = WAIT_LATCH;
                        low_n   = '0;
                    end else begin
                        shreg_n = word;
                        state_n = LOW;
                        low_n   = LW'(1);
                        if (bit_cnt == 5'd23) begin
                            bit_n = '0;
                            if (pix_cnt < LED_C) begin
                                data_n = word;
                                idx_n  = pix_cnt[IW-1:0];
                                pv_n   = 1'b1;
                                pix_n  = pix_cnt + 1'b1;
                            end else if (!ovf_seen) begin
                                ov_n       = 1'b1;
                                ovf_seen_n = 1'b1;
                            end
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end else if (high_cnt >= MAXH_M1) begin
                    // this sample makes the pulse MAX_HIGH long
                    be_n    = 1'b1;
                    state_n = WAIT_LATCH;
                    low_n   = '0;
                end else begin
                    high_n = high_cnt + 1'b1;
                end
            end

            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    high_n  = HW'(1);
                end else if (low_cnt >= LAT_M1) begin
                    if (bit_cnt != 5'd0) be_n = 1'b1;
                    fpix_n     = pix_cnt;
                    fd_n       = 1'b1;
                    pix_n      = '0;
                    bit_n      = '0;
                    low_n      = '0;
                    ovf_seen_n = 1'b0;
                    state_n    = IDLE;
                end else begin
                    low_n = low_cnt + 1'b1;
                end
            end

            WAIT_LATCH: begin
                // any high sample restarts the latch timer
                if (din_s) begin
                    low_n = '0;
                end else if (low_cnt >= LAT_M1) begin
                    high_n     = '0;
                    low_n      = '0;
                    bit_n      = '0;
                    pix_n      = '0;
                    ovf_seen_n = 1'b0;
                    state_n    = IDLE;
                end else begin
                    low_n = low_cnt + 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end
endmodule
